hex_keypad_scan: RTL and testbench



---
 rtl/hex_keypad_scan.sv | 198 +++++++++++++++++++
 tb/tb_hex_keypad_scan.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scan.sv
// 4x4 hex keypad scanner: rotates an active-low column drive, debounces a row hit,
// and shifts each accepted hex code into a 16-bit four-digit display register.
module hex_keypad_scan #(
  parameter int unsigned SCAN_DIV_BITS  = 14,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned RELEASE_TICKS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  kp_row,
  input  logic        clr,
  output logic [3:0]  kp_col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] data
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic [SCAN_DIV_BITS-1:0] r_div;
  logic [3:0]               r_rs1;
  logic [3:0]               r_rs2;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [3:0]               r_kp_col;
  logic [3:0]               w_kp_col_nxt;
  logic [1:0]               r_cand_row;
  logic [1:0]               w_cand_row_nxt;
  logic [CNT_W-1:0]         r_deb_cnt;
  logic [CNT_W-1:0]         w_deb_cnt_nxt;
  logic [CNT_W-1:0]         r_rel_cnt;
  logic [CNT_W-1:0]         w_rel_cnt_nxt;
  logic                     r_key_valid;
  logic [3:0]               r_key_code;
  logic [15:0]              r_data;

  logic                     w_tick;
  logic                     w_pressed;
  logic [1:0]               w_sel_row;
  logic [1:0]               w_col_idx;
  logic [3:0]               w_code;
  logic                     w_accept;

  // Key legend by {row, column}
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  assign w_tick    = &r_div;
  assign w_pressed = ~(&r_rs2);

  // Lowest-indexed low row wins when several are pressed
  always_comb begin
    w_sel_row = 2'd0;
    if (!r_rs2[0])      w_sel_row = 2'd0;
    else if (!r_rs2[1]) w_sel_row = 2'd1;
    else if (!r_rs2[2]) w_sel_row = 2'd2;
    else if (!r_rs2[3]) w_sel_row = 2'd3;
  end

  always_comb begin
    w_col_idx = 2'd0;
    case (r_kp_col)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  assign w_code = key_map(w_sel_row, w_col_idx);

  // Next-state logic; the column is only rotated from SCAN on a quiet tick
  always_comb begin
    w_state_nxt    = r_state;
    w_kp_col_nxt   = r_kp_col;
    w_cand_row_nxt = r_cand_row;
    w_deb_cnt_nxt  = r_deb_cnt;
    w_rel_cnt_nxt  = r_rel_cnt;
    w_accept       = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (!w_pressed) begin
            w_kp_col_nxt = {r_kp_col[2:0], r_kp_col[3]};
          end else begin
            w_cand_row_nxt = w_sel_row;
            if (DEBOUNCE_TICKS == 1) begin
              w_accept      = 1'b1;
              w_deb_cnt_nxt = '0;
              w_state_nxt   = ST_HELD;
            end else begin
              w_deb_cnt_nxt = CNT_W'(1);
              w_state_nxt   = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_pressed && (w_sel_row == r_cand_row)) begin
            if (r_deb_cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
              w_accept      = 1'b1;
              w_deb_cnt_nxt = '0;
              w_state_nxt   = ST_HELD;
            end else begin
              w_deb_cnt_nxt = r_deb_cnt + CNT_W'(1);
            end
          end else begin
            w_deb_cnt_nxt = '0;
            w_state_nxt   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (r_rs2 == 4'b1111) begin
            if (r_rel_cnt == CNT_W'(RELEASE_TICKS - 1)) begin
              w_rel_cnt_nxt = '0;
              w_state_nxt   = ST_SCAN;
            end else begin
              w_rel_cnt_nxt = r_rel_cnt + CNT_W'(1);
            end
          end else begin
            w_rel_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  // FSM and scan registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_rs1      <= 4'b1111;
      r_rs2      <= 4'b1111;
      r_state    <= ST_SCAN;
      r_kp_col   <= 4'b1110;
      r_cand_row <= 2'd0;
      r_deb_cnt  <= '0;
      r_rel_cnt  <= '0;
    end else begin
      r_div      <= r_div + SCAN_DIV_BITS'(1);
      r_rs1      <= kp_row;
      r_rs2      <= r_rs1;
      r_state    <= w_state_nxt;
      r_kp_col   <= w_kp_col_nxt;
      r_cand_row <= w_cand_row_nxt;
      r_deb_cnt  <= w_deb_cnt_nxt;
      r_rel_cnt  <= w_rel_cnt_nxt;
    end
  end

  // Accepted-key outputs; clr wins over a simultaneous shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_data      <= 16'h0000;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_code;
      if (clr)           r_data <= 16'h0000;
      else if (w_accept) r_data <= {r_data[11:0], w_code};
    end
  end

  assign kp_col    = r_kp_col;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign data      = r_data;

endmodule

// File: tb/tb_hex_keypad_scan.sv
// Bench for hex_keypad_scan: a keypad matrix model driven by a set of held keys,
// directed scenarios plus random key sequences checked against a digit-shift model.
module tb_hex_keypad_scan;

  localparam int unsigned TICK = 16;

  logic        clk;
  logic        reset;
  logic [3:0]  kp_row;
  logic        clr;
  logic [3:0]  kp_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data;

  logic [15:0] held;
  logic [15:0] exp_data;
  logic [3:0]  exp_code;
  int          total;
  int          bad;
  int          pulses;
  string       layout [4] = '{"123A", "456B", "789C", "E0FD"};

  hex_keypad_scan #(
    .SCAN_DIV_BITS (4),
    .DEBOUNCE_TICKS(4),
    .RELEASE_TICKS (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .kp_row   (kp_row),
    .clr      (clr),
    .kp_col   (kp_col),
    .key_valid(key_valid),
    .key_code (key_code),
    .data     (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix: a held key pulls its row low while its column is driven low
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid) pulses++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] hexval(input byte ch);
    if (ch >= 8'h41) return 4'(ch - 8'h37);
    return 4'(ch - 8'h30);
  endfunction

  task automatic key_pos(input logic [3:0] k, output int r, output int c);
    r = 0;
    c = 0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (hexval(layout[rr].getc(cc)) == k) begin
          r = rr;
          c = cc;
        end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * TICK) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_clk, output int waited);
    waited = 0;
    while (!key_valid && waited < max_clk) begin
      @(negedge clk);
      waited++;
    end
    chk("valid_seen", 32'(key_valid), 32'd1);
  endtask

  task automatic model_accept(input logic [3:0] k);
    exp_code = k;
    exp_data = {exp_data[11:0], k};
  endtask

  // Wait until the scan freshly lands on the given column
  task automatic align_col(input int c);
    logic [3:0] target;
    int n;
    target = 4'hF ^ (4'(1) << c);
    n = 0;
    while (kp_col == target && n < 200) begin @(negedge clk); n++; end
    while (kp_col != target && n < 400) begin @(negedge clk); n++; end
    chk("align_col", 32'(kp_col), 32'(target));
  endtask

  task automatic press_key(input logic [3:0] k, input int extra, input int rel, input string tag);
    int r, c, w, start;
    key_pos(k, r, c);
    start = pulses;
    held[r*4+c] = 1'b1;
    wait_valid(30 * TICK, w);
    model_accept(k);
    chk({tag, "_code"}, 32'(key_code), 32'(exp_code));
    chk({tag, "_data"}, 32'(data), 32'(exp_data));
    @(negedge clk);
    chk({tag, "_pulse_width"}, 32'(key_valid), 32'd0);
    ticks(extra);
    held[r*4+c] = 1'b0;
    ticks(rel);
    chk({tag, "_pulse_count"}, 32'(pulses - start), 32'd1);
  endtask

  initial begin
    int r, c, w, start, n, run, changes;
    logic [3:0] prev;
    total    = 0;
    bad      = 0;
    pulses   = 0;
    held     = 16'h0;
    clr      = 1'b0;
    reset    = 1'b1;
    exp_data = 16'h0;
    exp_code = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(kp_col), 32'hE);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    reset = 1'b0;

    // Idle scan: rotation order, 16-clock dwell, no key activity
    prev = kp_col;
    run = 0;
    changes = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      run++;
      if (kp_col != prev) begin
        chk("idle_rotate", 32'(kp_col), 32'({prev[2:0], prev[3]}));
        if (changes > 0) chk("idle_dwell", 32'(run), 32'(TICK));
        changes++;
        run = 0;
        prev = kp_col;
      end
    end
    chk("idle_changes", 32'(changes), 32'd12);
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_data", 32'(data), 32'd0);

    // Key 6 (row 1, column 2): freeze at 1011 and accept four ticks after arrival
    n = 0;
    while (kp_col != 4'b1110 && n < 100) begin @(negedge clk); n++; end
    start = pulses;
    key_pos(4'h6, r, c);
    held[r*4+c] = 1'b1;
    n = 0;
    while (kp_col != 4'b1011 && n < 100) begin @(negedge clk); n++; end
    wait_valid(20 * TICK, w);
    chk("k6_latency", 32'(w), 32'(4 * TICK));
    model_accept(4'h6);
    chk("k6_col", 32'(kp_col), 32'hB);
    chk("k6_code", 32'(key_code), 32'h6);
    chk("k6_data", 32'(data), 32'h0006);
    ticks(3);
    chk("k6_frozen", 32'(kp_col), 32'hB);
    held[r*4+c] = 1'b0;
    ticks(5);
    chk("k6_pulses", 32'(pulses - start), 32'd1);

    // Digit sequence
    press_key(4'h1, 2, 5, "seq1");
    press_key(4'h2, 2, 5, "seq2");
    press_key(4'h3, 2, 5, "seq3");
    press_key(4'h4, 2, 5, "seq4");
    chk("seq_1234", 32'(data), 32'h1234);
    press_key(4'h0, 2, 5, "seq0");
    chk("seq_2340", 32'(data), 32'h2340);

    // Two rows in one column: the lower row index wins (5 over 8)
    start = pulses;
    held[1*4+1] = 1'b1;
    held[2*4+1] = 1'b1;
    wait_valid(30 * TICK, w);
    model_accept(4'h5);
    chk("prio_code", 32'(key_code), 32'(exp_code));
    chk("prio_data", 32'(data), 32'(exp_data));
    held = 16'h0;
    ticks(5);
    chk("prio_pulses", 32'(pulses - start), 32'd1);

    // Bounce on key 7: two low ticks, one high, then steady
    key_pos(4'h7, r, c);
    align_col(c);
    start = pulses;
    held[r*4+c] = 1'b1;
    repeat (38) @(negedge clk);
    held[r*4+c] = 1'b0;
    repeat (16) @(negedge clk);
    held[r*4+c] = 1'b1;
    wait_valid(20 * TICK, w);
    chk("bounce_latency", 32'(38 + 16 + w), 32'(7 * TICK));
    model_accept(4'h7);
    chk("bounce_code", 32'(key_code), 32'h7);
    ticks(2);
    held[r*4+c] = 1'b0;
    ticks(5);
    chk("bounce_pulses", 32'(pulses - start), 32'd1);

    // Long hold with a short release glitch, then a clean second press
    key_pos(4'hF, r, c);
    start = pulses;
    held[r*4+c] = 1'b1;
    wait_valid(30 * TICK, w);
    model_accept(4'hF);
    ticks(22);
    held[r*4+c] = 1'b0;
    ticks(2);
    held[r*4+c] = 1'b1;
    ticks(25);
    held[r*4+c] = 1'b0;
    ticks(5);
    chk("glitch_pulses", 32'(pulses - start), 32'd1);
    press_key(4'hF, 1, 5, "repress");

    // clr coincident with the accept of key 9
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_data = 16'h0;
    chk("clr_data", 32'(data), 32'd0);
    press_key(4'hA, 1, 5, "ab_a");
    press_key(4'hB, 1, 5, "ab_b");
    chk("ab_data", 32'(data), 32'h00AB);
    key_pos(4'h9, r, c);
    align_col(c);
    held[r*4+c] = 1'b1;
    repeat (4 * TICK - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clracc_valid", 32'(key_valid), 32'd1);
    chk("clracc_code", 32'(key_code), 32'h9);
    chk("clracc_data", 32'(data), 32'd0);
    exp_code = 4'h9;
    exp_data = 16'h0;
    ticks(2);
    held[r*4+c] = 1'b0;
    ticks(5);

    // Reset in the middle of debouncing key 2
    key_pos(4'h2, r, c);
    align_col(c);
    held[r*4+c] = 1'b1;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstdeb_col", 32'(kp_col), 32'hE);
    chk("rstdeb_valid", 32'(key_valid), 32'd0);
    chk("rstdeb_code", 32'(key_code), 32'd0);
    chk("rstdeb_data", 32'(data), 32'd0);
    held[r*4+c] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_data = 16'h0;
    exp_code = 4'h0;
    start = pulses;
    ticks(10);
    chk("rstdeb_no_pulse", 32'(pulses - start), 32'd0);

    // Random key sequence with occasional clears
    for (int i = 0; i < 10; i++) begin
      press_key(4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(5, 8), "rand");
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_data = 16'h0;
        chk("rand_clr", 32'(data), 32'd0);
      end
    end
    chk("final_data", 32'(data), 32'(exp_data));
    chk("final_code", 32'(key_code), 32'(exp_code));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
